// File: rtl/uart_pkg.sv
// Shared UART definitions: legal oversampling ratios, default widths and a
// divisor calculator for benches and firmware header generation.
package uart_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_FRAC_W = 3;

  // Bit n set means OSR=n is supported (4, 8, 16).
  localparam logic [16:0] OSR_LEGAL_MASK = 17'h10110;

  typedef struct packed {
    logic [31:0] val;
    logic [31:0] frac;
  } baud_div_t;

  // Rounded clk_hz/(baud*osr) in units of 1/2^frac_w clk, split into the
  // reload value (period-1) and the fractional remainder.
  function automatic baud_div_t calc_baud_div(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input int unsigned     osr,
    input int unsigned     frac_w
  );
    baud_div_t       d;
    longint unsigned tick_rate;
    longint unsigned scaled;
    tick_rate = baud * longint'(osr);
    scaled    = ((clk_hz << frac_w) + (tick_rate >> 1)) / tick_rate;
    d.val     = 32'((scaled >> frac_w) - 64'd1);
    d.frac    = 32'(scaled & ((64'd1 << frac_w) - 64'd1));
    return d;
  endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional accumulator: adds frac on every tick and requests a one-cycle
// period stretch whenever the sum carries out.
module uart_frac_acc #(
  parameter int FRAC_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              acc_clr,
  input  logic              pend_clr,
  input  logic              tick_in,
  input  logic [FRAC_W-1:0] frac,
  output logic              stretch_out
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              pend_q, pend_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    acc_d  = acc_q;
    pend_d = pend_q;
    sum    = {1'b0, acc_q} + {1'b0, frac};
    if (acc_clr) begin
      acc_d  = '0;
      pend_d = 1'b0;
    end else if (pend_clr) begin
      // Restart keeps the accumulated phase; only the pending stretch drops.
      pend_d = 1'b0;
    end else if (tick_in) begin
      acc_d  = sum[FRAC_W-1:0];
      pend_d = sum[FRAC_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      pend_q <= pend_d;
    end
  end

  assign stretch_out = pend_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate generator: programmable integer+fractional divider producing the
// oversampling tick, the once-per-bit transmit pulse and the oversampling phase.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OSR    = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic                                restart,
  input  logic [CNT_W-1:0]                    baud_val,
  input  logic [(FRAC_W > 0 ? FRAC_W : 1)-1:0] baud_frac,
  output logic                                baud_tick,
  output logic                                xmit_pulse,
  output logic [$clog2(OSR)-1:0]              osr_phase
);

  localparam int PH_W = $clog2(OSR);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  osr_cnt_q, osr_cnt_d;
  logic             tick_q, tick_d;
  logic             xmit_q, xmit_d;
  logic             stretch_pend;
  logic             cnt_zero;
  logic             tick_now;

  assign cnt_zero = (cnt_q == '0);
  assign tick_now = enable && !restart && cnt_zero && !stretch_pend;

  generate
    if (FRAC_W > 0) begin : g_frac
      uart_frac_acc #(
        .FRAC_W (FRAC_W)
      ) u_frac_acc (
        .clk         (clk),
        .reset_n     (reset_n),
        .acc_clr     (!enable),
        .pend_clr    (restart || (cnt_zero && stretch_pend)),
        .tick_in     (tick_now),
        .frac        (baud_frac),
        .stretch_out (stretch_pend)
      );
    end else begin : g_no_frac
      assign stretch_pend = 1'b0;
    end
  endgenerate

  always_comb begin
    cnt_d     = cnt_q;
    osr_cnt_d = osr_cnt_q;
    tick_d    = 1'b0;
    xmit_d    = 1'b0;
    if (!enable || restart) begin
      cnt_d     = baud_val;
      osr_cnt_d = '0;
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (!stretch_pend) begin
      // Reload point: the only cycle where baud_val is sampled.
      tick_d    = 1'b1;
      cnt_d     = baud_val;
      osr_cnt_d = osr_cnt_q + PH_W'(1);
      xmit_d    = (osr_cnt_q == PH_W'(OSR - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      osr_cnt_q <= '0;
      tick_q    <= 1'b0;
      xmit_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      osr_cnt_q <= osr_cnt_d;
      tick_q    <= tick_d;
      xmit_q    <= xmit_d;
    end
  end

  assign baud_tick  = tick_q;
  assign xmit_pulse = xmit_q;
  assign osr_phase  = osr_cnt_q;

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud-rate generator for the UART cores.
- Divides clk to an oversampling tick with a programmable integer divisor and an N-bit fractional divisor.
- The fractional part uses an accumulator with one-cycle stretch insertion, rather than fixed bit-pattern decoding.
- Derives the once-per-bit transmit pulse and exposes the oversampling phase for receiver bit-centre sampling.
- Sits between the register block (baud_val/baud_frac) and the tx/rx shifters.

Parameters:
- CNT_W, 16: width of the integer divisor and the down-counter.
- FRAC_W, 3: fractional divisor bits. 0 removes all fractional logic.
- OSR, 16: oversampling ratio. Legal values 4, 8, 16; power of two only.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- enable  in  1  generator run enable; synchronous.
- restart  in  1  one-cycle synchronous phase restart (receiver start-bit alignment).
- baud_val  in  CNT_W  integer divisor; tick period = baud_val+1 clk.
- baud_frac  in  max(FRAC_W,1)  fractional divisor in units of 1/2^FRAC_W clk; ignored when FRAC_W=0.
- baud_tick  out  1  oversampling tick, one clk wide.
- xmit_pulse  out  1  once-per-bit pulse, one clk wide, coincident with a baud_tick.
- osr_phase  out  clog2(OSR)  current oversampling phase, 0..OSR-1.

Behaviour:
- Reset (async): cnt=0, acc=0, stretch_pend=0, osr_cnt=0; baud_tick=0, xmit_pulse=0, osr_phase=0.
- State elements:
  - cnt[CNT_W]: down-counter.
  - acc[FRAC_W]: fractional accumulator.
  - stretch_pend: one bit.
  - osr_cnt[clog2(OSR)]: oversampling counter.
- All outputs are registered.
- Normal run (enable=1, restart=0), each clk:
  - cnt!=0: cnt<=cnt-1; baud_tick<=0.
  - cnt==0 and stretch_pend=1: hold cnt at 0; stretch_pend<=0; baud_tick<=0. This inserts exactly one extra cycle.
  - cnt==0 and stretch_pend=0:
    - baud_tick<=1; cnt<=baud_val.
    - {carry,acc}<=acc+baud_frac, computed FRAC_W+1 bits wide, modulo 2^FRAC_W.
    - stretch_pend<=carry.
    - osr_cnt<=osr_cnt+1, wrapping OSR-1 to 0.
    - xmit_pulse<=1 iff the pre-increment osr_cnt==OSR-1.
- Tick interval: baud_val+1 clk, or +1 when the preceding tick produced a carry.
- Invariant: any 2^FRAC_W consecutive tick intervals sum to 2^FRAC_W*(baud_val+1)+baud_frac, provided baud_frac is constant.
- FRAC_W=0: acc and stretch_pend do not exist; interval is always baud_val+1.
- baud_val and baud_frac are sampled only at reload, i.e. the tick cycle. A mid-period change takes effect on the next period; the current count is not disturbed.
- baud_val=0, baud_frac=0: baud_tick high every cycle. With baud_frac!=0, single idle cycles are inserted per carry.
- osr_phase = osr_cnt. It updates in the same cycle baud_tick is asserted.
- enable=0, synchronous and highest priority after reset:
  - cnt<=baud_val; acc<=0; stretch_pend<=0; osr_cnt<=0.
  - baud_tick<=0; xmit_pulse<=0.
  - After enable rises, the first tick occurs baud_val+1 cycles later.
- restart=1 (with enable=1):
  - cnt<=baud_val; stretch_pend<=0; osr_cnt<=0; baud_tick<=0; xmit_pulse<=0.
  - acc is retained.
  - restart takes priority over a tick due in the same cycle.
- Reset asserted mid-operation: immediate clear as listed under Reset; no partial pulse completes.
- xmit_pulse never occurs without baud_tick in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - Legal OSR values constant.
  - Default CNT_W and FRAC_W.
  - Function computing baud_val/baud_frac from clk frequency and baud rate, for benches and firmware headers.
- One sub-module is natural: uart_frac_acc, containing the accumulator, carry and stretch_pend. Its interface is tick_in, frac, stretch_out.
- It is omitted via generate when FRAC_W=0.

Test Plan:
1. OSR=16, baud_val=3, baud_frac=0, enable=1 → baud_tick every 4 clk; xmit_pulse every 64 clk, on the tick where osr_phase wraps 15→0.
2. FRAC_W=3, baud_val=3, baud_frac=4 → intervals alternate 4,5; any 8 consecutive intervals total 36 clk.
3. FRAC_W=3, baud_val=3, baud_frac=7 → steady state has 7 of every 8 intervals at 5 clk; 8 consecutive intervals total 39 clk.
4. baud_val=0, baud_frac=0 → baud_tick continuously high; xmit_pulse every 16 clk. Then baud_frac=4 → pattern tick,tick,idle repeating.
5. Mid-period changes:
   - baud_val 3→9 at cnt=2 → current interval completes at 4 clk; the next is 10 clk.
   - restart pulse → no tick for baud_val+1 cycles; osr_phase=0.
   - enable low for 5 clk → outputs 0; first tick baud_val+1 cycles after re-enable.
6. reset_n asserted asynchronously while baud_tick=1 → baud_tick, xmit_pulse and osr_phase are 0 before the next clk edge. After release, behaviour matches scenario 1 from zero.
